// File: rtl/midori64_share_feeder_pkg.sv
// Shared constants, types and helpers for the Midori64 share feeder.
package midori64_feeder_pkg;

  localparam int SLOTS = 3;    // pipeline slots in the masked core
  localparam int DW    = 64;   // data block width
  localparam int KW    = 128;  // key width (also the width of rand_in)
  localparam int RW    = 72;   // per-cycle core randomness width

  // Feedback taps of the r LFSR, numbered 1..RW from the LSB.
  localparam int R_TAP_A = 72;
  localparam int R_TAP_B = 66;
  localparam int R_TAP_C = 25;
  localparam int R_TAP_D = 19;

  localparam logic [RW-1:0] R_TAP_MASK = (RW'(1) << (R_TAP_A - 1))
                                       | (RW'(1) << (R_TAP_B - 1))
                                       | (RW'(1) << (R_TAP_C - 1))
                                       | (RW'(1) << (R_TAP_D - 1));

  typedef enum logic [2:0] {
    COLLECT,
    KEY1,
    LOAD,
    RUN,
    DRAIN
  } state_e;

  // Three Boolean shares of one data block: word = s1 ^ s2 ^ s3.
  typedef struct packed {
    logic [DW-1:0] s1;
    logic [DW-1:0] s2;
    logic [DW-1:0] s3;
  } share_t;

  // Split a word into three shares; the low half of rnd becomes s2, the high half s3.
  function automatic share_t mask_word(input logic [DW-1:0] word, input logic [KW-1:0] rnd);
    share_t sh;
    sh.s2 = rnd[DW-1:0];
    sh.s3 = rnd[KW-1:DW];
    sh.s1 = word ^ sh.s2 ^ sh.s3;
    return sh;
  endfunction

  // One left shift of the Fibonacci LFSR; the new LSB is the XOR of the tapped bits.
  function automatic logic [RW-1:0] r_lfsr_next(input logic [RW-1:0] s);
    logic fb;
    fb = ^(s & R_TAP_MASK);
    return {s[RW-2:0], fb};
  endfunction

endpackage

// File: rtl/midori64_share_feeder_if.sv
// Upstream key/plaintext handshakes plus mode, flush and fresh randomness.
interface midori64_share_feeder_if;
  import midori64_feeder_pkg::*;

  logic          key_valid;
  logic          key_ready;
  logic [KW-1:0] key;
  logic          pt_valid;
  logic          pt_ready;
  logic [DW-1:0] pt;
  logic          enc_dec_in;
  logic          flush;
  logic [KW-1:0] rand_in;

  // Producer side (data source and randomness source).
  modport master (
    output key_valid, key, pt_valid, pt, enc_dec_in, flush, rand_in,
    input  key_ready, pt_ready
  );

  // Feeder side.
  modport slave (
    input  key_valid, key, pt_valid, pt, enc_dec_in, flush, rand_in,
    output key_ready, pt_ready
  );

endinterface

// File: rtl/midori64_r_lfsr.sv
// 72-bit Fibonacci LFSR supplying the core's per-cycle mask r.
module midori64_r_lfsr
  import midori64_feeder_pkg::*;
#(
  parameter logic [RW-1:0] SEED = 72'h5A_0F1E_2D3C_4B5A_6978
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [RW-1:0] q
);

  logic [RW-1:0] r_q, r_d;

  // Advance only when enabled, otherwise hold.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a default first, so no path can infer a latch.
    r_d = r_q;
    if (en) r_d = r_lfsr_next(r_q);
  end

  // State register; a nonzero seed on an invertible linear map never reaches zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential blocks use non-blocking '<=' so every flop samples the pre-edge values.
    if (!reset) r_q <= SEED;
    else        r_q <= r_d;
  end

  assign q = r_q;

endmodule

// File: rtl/midori64_share_feeder.sv
// Splits key and plaintexts into three Boolean shares, loads the masked core's
// three pipeline slots under reset, releases it and waits for the batch to drain.
module midori64_share_feeder
  import midori64_feeder_pkg::*;
#(
  parameter logic [RW-1:0] R_SEED = 72'h5A_0F1E_2D3C_4B5A_6978
) (
  input  logic                     clk,
  input  logic                     reset,
  midori64_share_feeder_if.slave   up,
  output logic                     core_reset,
  output logic [DW-1:0]            core_in1,
  output logic [DW-1:0]            core_in2,
  output logic [DW-1:0]            core_in3,
  output logic [KW-1:0]            core_key1,
  output logic [KW-1:0]            core_key2,
  output logic [KW-1:0]            core_key3,
  output logic [RW-1:0]            core_r,
  output logic                     core_enc_dec,
  input  logic                     core_done,
  output logic                     busy,
  output logic                     batch_done
);

  state_e        state_q, state_d;
  logic [1:0]    count_q, count_d;       // plaintexts held in the share buffer
  logic [1:0]    phase_q, phase_d;       // LOAD slot index / DRAIN cycle index
  logic          key_loaded_q, key_loaded_d;
  logic [KW-1:0] key_hold_q, key_hold_d; // key ^ first key mask, live only across KEY1
  share_t        slot_q [SLOTS];
  share_t        slot_d [SLOTS];
  share_t        out_q, out_d;           // shares currently presented to the core
  logic [KW-1:0] key1_q, key1_d;
  logic [KW-1:0] key2_q, key2_d;
  logic [KW-1:0] key3_q, key3_d;
  logic          enc_dec_q, enc_dec_d;
  logic          core_reset_q, core_reset_d;
  logic          batch_done_q, batch_done_d;

  logic          key_ready_c, pt_ready_c;
  logic          key_fire, pt_fire, lfsr_en;
  share_t        pt_share, zero_share;

  // Handshake readies from registered state; a key offered alongside a plaintext wins.
  assign key_ready_c = (state_q == COLLECT) && (count_q == 2'd0);
  assign pt_ready_c  = (state_q == COLLECT) && key_loaded_q && (count_q < 2'(SLOTS))
                       && !(up.key_valid && key_ready_c);
  assign key_fire    = up.key_valid && key_ready_c;
  assign pt_fire     = up.pt_valid && pt_ready_c;

  assign pt_share    = mask_word(up.pt, up.rand_in);
  assign zero_share  = mask_word('0, up.rand_in);

  // Next-state, share buffer and output-register updates.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    phase_d      = phase_q;
    key_loaded_d = key_loaded_q;
    key_hold_d   = key_hold_q;
    slot_d       = slot_q;
    out_d        = out_q;
    key1_d       = key1_q;
    key2_d       = key2_q;
    key3_d       = key3_q;
    enc_dec_d    = enc_dec_q;
    batch_done_d = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (key_fire) begin
          key2_d     = up.rand_in;
          key_hold_d = up.key ^ up.rand_in;
          state_d    = KEY1;
        end else begin
          if (pt_fire) begin
            slot_d[count_q] = pt_share;
            count_d         = count_q + 2'd1;
            if (count_q == 2'd0) enc_dec_d = up.enc_dec_in;
          end
          // A plaintext accepted this cycle counts toward both exit conditions.
          if ((count_d == 2'(SLOTS)) || (up.flush && (count_d != 2'd0))) begin
            state_d = LOAD;
            phase_d = 2'd0;
            out_d   = slot_d[0];
          end
        end
      end

      KEY1: begin
        key3_d       = up.rand_in;
        key1_d       = key_hold_q ^ up.rand_in;
        key_hold_d   = '0;
        key_loaded_d = 1'b1;
        state_d      = COLLECT;
      end

      LOAD: begin
        if (phase_q == 2'(SLOTS - 1)) begin
          state_d = RUN;
          phase_d = 2'd0;
        end else begin
          phase_d = phase_q + 2'd1;
          // Unused slots carry a fresh masking of zero.
          out_d   = (phase_d < count_q) ? slot_q[phase_d] : zero_share;
        end
      end

      RUN: begin
        if (core_done) begin
          state_d = DRAIN;
          phase_d = 2'd0;
        end
      end

      DRAIN: begin
        if (phase_q == 2'd0) begin
          phase_d      = 2'd1;
          batch_done_d = 1'b1;
        end else begin
          state_d = COLLECT;
          phase_d = 2'd0;
          count_d = 2'd0;
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase

    core_reset_d = !((state_d == RUN) || (state_d == DRAIN));
  end

  // State and output registers; reset aborts everything, including the loaded key.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= COLLECT;
      count_q      <= 2'd0;
      phase_q      <= 2'd0;
      key_loaded_q <= 1'b0;
      key_hold_q   <= '0;
      // NOTE: the share buffer is reset on purpose so an aborted batch leaves no key or data shares behind.
      slot_q       <= '{default: '0};
      out_q        <= '0;
      key1_q       <= '0;
      key2_q       <= '0;
      key3_q       <= '0;
      enc_dec_q    <= 1'b0;
      core_reset_q <= 1'b1;
      batch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      phase_q      <= phase_d;
      key_loaded_q <= key_loaded_d;
      key_hold_q   <= key_hold_d;
      slot_q       <= slot_d;
      out_q        <= out_d;
      key1_q       <= key1_d;
      key2_q       <= key2_d;
      key3_q       <= key3_d;
      enc_dec_q    <= enc_dec_d;
      core_reset_q <= core_reset_d;
      batch_done_q <= batch_done_d;
    end
  end

  // r advances while the core is being loaded, running or draining.
  assign lfsr_en = (state_q == LOAD) || (state_q == RUN) || (state_q == DRAIN);

  midori64_r_lfsr #(
    .SEED (R_SEED)
  ) u_r_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .q     (core_r)
  );

  assign up.key_ready  = key_ready_c;
  assign up.pt_ready   = pt_ready_c;
  assign core_reset    = core_reset_q;
  assign core_in1      = out_q.s1;
  assign core_in2      = out_q.s2;
  assign core_in3      = out_q.s3;
  assign core_key1     = key1_q;
  assign core_key2     = key2_q;
  assign core_key3     = key3_q;
  assign core_enc_dec  = enc_dec_q;
  assign busy          = (state_q != COLLECT);
  assign batch_done    = batch_done_q;

endmodule

// File: tb/tb_midori64_share_feeder.sv
// Directed bench for midori64_share_feeder: key masking, full and partial
// batches, back-pressure, key/plaintext collision and reset abort.
module tb_midori64_share_feeder;

  localparam logic [71:0]  SEED = 72'h5A_0F1E_2D3C_4B5A_6978;
  localparam logic [127:0] KEY0 = 128'h687ded3b3c85b3f35b1009863e2a8cbf;
  localparam logic [127:0] KEY1 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [63:0]  PT_A = 64'h42c20fd3b586879e;
  localparam logic [63:0]  PT_B = 64'h1122334455667788;

  typedef struct {
    logic [63:0] pt;
    logic [63:0] r_lo;
    logic [63:0] r_hi;
    logic [63:0] s1;
  } vec_t;

  logic         clk, reset, core_done;
  logic         core_reset, core_enc_dec, busy, batch_done;
  logic [63:0]  core_in1, core_in2, core_in3;
  logic [127:0] core_key1, core_key2, core_key3;
  logic [71:0]  core_r;
  logic [71:0]  r_exp;
  logic [127:0] rnd_a, rnd_b;
  int           n_vec, n_fail;
  vec_t         vec [3];

  midori64_share_feeder_if up ();

  midori64_share_feeder #(.R_SEED(SEED)) dut (
    .clk          (clk),
    .reset        (reset),
    .up           (up),
    .core_reset   (core_reset),
    .core_in1     (core_in1),
    .core_in2     (core_in2),
    .core_in3     (core_in3),
    .core_key1    (core_key1),
    .core_key2    (core_key2),
    .core_key3    (core_key3),
    .core_r       (core_r),
    .core_enc_dec (core_enc_dec),
    .core_done    (core_done),
    .busy         (busy),
    .batch_done   (batch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] lfsr_step(input logic [71:0] s);
    logic fb;
    fb = s[71] ^ s[65] ^ s[24] ^ s[18];
    return {s[70:0], fb};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One clock edge; adv tells the model whether the cycle just ended was in LOAD/RUN/DRAIN.
  task automatic tick(input bit adv);
    @(posedge clk);
    #1;
    if (adv) r_exp = lfsr_step(r_exp);
    up.rand_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    vec[0] = '{pt: PT_A,                  r_lo: 64'h0,                  r_hi: 64'hffffffffffffffff, s1: 64'hbd3df02c4a797861};
    vec[1] = '{pt: 64'h0123456789abcdef,  r_lo: 64'h0123456789abcdef,  r_hi: 64'h0,                s1: 64'h0};
    vec[2] = '{pt: 64'hdeadbeefcafef00d,  r_lo: 64'h00000000ffffffff,  r_hi: 64'hffffffff00000000, s1: 64'h2152411035010ff2};

    reset = 1'b0;
    core_done = 1'b0;
    up.key_valid = 1'b0;
    up.key = '0;
    up.pt_valid = 1'b0;
    up.pt = '0;
    up.enc_dec_in = 1'b0;
    up.flush = 1'b0;
    up.rand_in = '0;
    r_exp = SEED;

    // ---- reset state ----
    tick(0);
    tick(0);
    #1;
    check("rst core_reset", core_reset, 1);
    check("rst key_ready", up.key_ready, 1);
    check("rst pt_ready", up.pt_ready, 0);
    check("rst busy", busy, 0);
    check("rst batch_done", batch_done, 0);
    check("rst core_in1", core_in1, 0);
    check("rst core_key1", core_key1, 0);
    check("rst enc_dec", core_enc_dec, 0);
    check("rst core_r", core_r, SEED);
    reset = 1'b1;
    tick(0);
    up.pt_valid = 1'b1;
    #1 check("no key pt_ready", up.pt_ready, 0);
    up.pt_valid = 1'b0;

    // ---- key masking ----
    up.key_valid = 1'b1;
    up.key = KEY0;
    rnd_a = up.rand_in;
    #1 check("key_ready idle", up.key_ready, 1);
    tick(0);
    up.key_valid = 1'b0;
    rnd_b = up.rand_in;
    #1;
    check("KEY1 key_ready", up.key_ready, 0);
    check("KEY1 busy", busy, 1);
    check("key2 share", core_key2, rnd_a);
    tick(0);
    check("key shares xor", core_key1 ^ core_key2 ^ core_key3, KEY0);
    check("key3 share", core_key3, rnd_b);
    check("key2 masked", core_key2 == KEY0, 0);
    check("after key busy", busy, 0);

    // ---- flush with no plaintext is ignored ----
    up.flush = 1'b1;
    tick(0);
    up.flush = 1'b0;
    #1;
    check("empty flush busy", busy, 0);
    check("empty flush key_ready", up.key_ready, 1);

    // ---- full batch from the vector table ----
    for (int i = 0; i < 3; i++) begin
      up.pt_valid = 1'b1;
      up.pt = vec[i].pt;
      up.rand_in = {vec[i].r_hi, vec[i].r_lo};
      up.enc_dec_in = (i == 0);
      #1 check($sformatf("batch pt_ready %0d", i), up.pt_ready, 1);
      tick(0);
    end
    up.pt_valid = 1'b0;
    #1;
    check("full pt_ready drop", up.pt_ready, 0);
    check("full LOAD busy", busy, 1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("load%0d s1", k), core_in1, vec[k].s1);
      check($sformatf("load%0d s2", k), core_in2, vec[k].r_lo);
      check($sformatf("load%0d s3", k), core_in3, vec[k].r_hi);
      check($sformatf("load%0d core_reset", k), core_reset, 1);
      tick(1);
    end
    check("run core_reset", core_reset, 0);
    check("run core_r", core_r, r_exp);
    check("run enc_dec", core_enc_dec, 1);

    // ---- back-pressure during RUN / DRAIN ----
    up.pt_valid = 1'b1;
    up.pt = PT_A;
    up.enc_dec_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("run pt_ready %0d", c), up.pt_ready, 0);
      tick(1);
    end
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    #1;
    check("drain0 batch_done", batch_done, 0);
    check("drain0 core_reset", core_reset, 0);
    check("drain0 pt_ready", up.pt_ready, 0);
    tick(1);
    #1;
    check("drain1 batch_done", batch_done, 1);
    check("drain1 pt_ready", up.pt_ready, 0);
    check("drain1 core_reset", core_reset, 0);
    tick(1);
    #1;
    check("post batch_done", batch_done, 0);
    check("post core_reset", core_reset, 1);
    check("post busy", busy, 0);
    check("post core_r", core_r, r_exp);
    check("post pt_ready", up.pt_ready, 1);

    // ---- single plaintext then flush ----
    rnd_a = up.rand_in;
    tick(0);
    up.pt_valid = 1'b0;
    #1 check("single accepted", up.key_ready, 0);
    up.flush = 1'b1;
    tick(0);
    up.flush = 1'b0;
    #1;
    check("flush LOAD busy", busy, 1);
    check("slot0 xor", core_in1 ^ core_in2 ^ core_in3, PT_A);
    check("slot0 s2", core_in2, rnd_a[63:0]);
    check("single enc_dec", core_enc_dec, 0);
    for (int k = 1; k < 3; k++) begin
      rnd_b = up.rand_in;
      tick(1);
      check($sformatf("slot%0d zero xor", k), core_in1 ^ core_in2 ^ core_in3, 0);
      check($sformatf("slot%0d zero s2", k), core_in2, rnd_b[63:0]);
    end
    tick(1);
    check("single run core_reset", core_reset, 0);
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    tick(1);
    check("single batch_done", batch_done, 1);
    tick(1);
    check("single core_r", core_r, r_exp);

    // ---- key and plaintext offered together ----
    up.key_valid = 1'b1;
    up.key = KEY1;
    up.pt_valid = 1'b1;
    up.pt = PT_B;
    up.enc_dec_in = 1'b1;
    #1;
    check("collide key_ready", up.key_ready, 1);
    check("collide pt_ready", up.pt_ready, 0);
    tick(0);
    up.key_valid = 1'b0;
    #1 check("collide KEY1 pt_ready", up.pt_ready, 0);
    tick(0);
    check("key1 shares xor", core_key1 ^ core_key2 ^ core_key3, KEY1);
    #1 check("collide pt_ready after", up.pt_ready, 1);
    up.flush = 1'b1;
    rnd_a = up.rand_in;
    tick(0);
    up.pt_valid = 1'b0;
    up.flush = 1'b0;
    #1;
    check("same-cycle flush busy", busy, 1);
    check("same-cycle slot0 xor", core_in1 ^ core_in2 ^ core_in3, PT_B);
    check("same-cycle slot0 s3", core_in3, rnd_a[127:64]);
    check("same-cycle enc_dec", core_enc_dec, 1);
    tick(1);
    tick(1);
    tick(1);
    check("abort run core_reset", core_reset, 0);
    tick(1);

    // ---- reset during RUN ----
    reset = 1'b0;
    tick(0);
    r_exp = SEED;
    reset = 1'b1;
    #1;
    check("abort core_reset", core_reset, 1);
    check("abort core_r", core_r, r_exp);
    check("abort busy", busy, 0);
    check("abort core_in1", core_in1, 0);
    check("abort core_key1", core_key1, 0);
    up.pt_valid = 1'b1;
    up.pt = PT_A;
    #1 check("abort pt_ready", up.pt_ready, 0);
    tick(0);
    #1 check("abort pt_ready later", up.pt_ready, 0);
    up.key_valid = 1'b1;
    up.key = KEY0;
    tick(0);
    up.key_valid = 1'b0;
    tick(0);
    #1 check("reload pt_ready", up.pt_ready, 1);
    check("reload key xor", core_key1 ^ core_key2 ^ core_key3, KEY0);
    up.pt_valid = 1'b0;
    tick(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/midori64_share_feeder.md
# midori64_share_feeder

Upstream input stage for the 3-share masked, 3-stage-pipelined Midori64 core. It accepts an unmasked 128-bit key and up to three 64-bit plaintexts over valid/ready handshakes, and splits each into three Boolean shares using external fresh randomness. It then loads the core's three pipeline slots while holding the core in reset, releases the core, and sequences the 72-bit per-cycle mask `r`. It waits for `core_done` and for the three output cycles before accepting the next batch.

## Interface
- `R_SEED`, default 72'h5A_0F1E_2D3C_4B5A_6978, nonzero initial state of the `r` LFSR
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-low
- `key_valid` in 1 / `key_ready` out 1 / `key` in 128: key handshake
- `pt_valid` in 1 / `pt_ready` out 1 / `pt` in 64: plaintext handshake
- `enc_dec_in` in 1: mode, latched with the first plaintext of a batch
- `flush` in 1: start a partial batch (1–2 plaintexts)
- `rand_in` in 128: fresh randomness, consumed on each share generation
- `core_reset` out 1: active-high reset/load control to the core
- `core_in1`, `core_in2`, `core_in3` out 64 each: data shares
- `core_key1`, `core_key2`, `core_key3` out 128 each: key shares
- `core_r` out 72: core randomness
- `core_enc_dec` out 1: mode to the core
- `core_done` in 1: from the core
- `busy` out 1: high in every state except COLLECT
- `batch_done` out 1: single-cycle pulse

## Operation
- **Reset values:**
  - State COLLECT, `count`=0, `key_loaded`=0.
  - `core_reset`=1; all shares, key shares and `core_enc_dec` = 0; `core_r`=`R_SEED`.
  - `key_ready`=1, `pt_ready`=0, `busy`=0, `batch_done`=0.
- **COLLECT:**
  - `key_ready` = (`count`==0).
  - `pt_ready` = `key_loaded` & (`count`<3) & ~(`key_valid` & `key_ready`).
  - If a key and a plaintext are both offered, the key wins.
- **Key accept, then KEY1 (1 cycle, `key_ready`=0):**
  - On accept: `core_key2`=`rand_in`, hold `key`^`rand_in` internally.
  - In KEY1: `core_key3`=`rand_in`, `core_key1`=held value ^ `rand_in`.
  - Then `key_loaded`=1, return to COLLECT.
  - Invariant: `core_key1`^`core_key2`^`core_key3` == `key`.
- **Plaintext accept into slot[`count`]:**
  - s2=`rand_in`[63:0], s3=`rand_in`[127:64], s1=`pt`^s2^s3; `count`++.
  - First accept of a batch also latches `enc_dec_in`.
- **Leaving COLLECT:** go to LOAD when `count` reaches 3, or when `flush` is high with `count`≥1 (a plaintext accepted in the same cycle is included). `flush` with `count`==0 is ignored.
- **LOAD (3 cycles, `core_reset`=1):**
  - Cycle k drives slot k shares on `core_in1..3`.
  - Empty slots are a fresh masking of zero: s2,s3 from `rand_in`, s1=s2^s3.
- **RUN:** `core_reset`=0, shares held; wait for `core_done`. On `core_done`=1, go to DRAIN.
- **DRAIN (2 cycles):**
  - `core_reset` stays 0.
  - `batch_done` pulses in the second DRAIN cycle.
  - Next state COLLECT with `core_reset`=1 and `count`=0; `key_loaded` is kept.
- **`core_r` LFSR:**
  - 72-bit Fibonacci, XOR feedback taps 72, 66, 25, 19; shifts left.
  - Advances every cycle in LOAD, RUN and DRAIN; holds otherwise.
  - Never reaches all-zero.
- **Reset mid-operation:** an abort; all state returns to reset values. The key must be reloaded.

## Timing
- Key load: 2 cycles (accept + KEY1).
- Batch: 3 LOAD cycles, then RUN until `core_done`, then 2 DRAIN cycles.
- `core_reset` falls on the cycle after the third LOAD cycle.
- All outputs are registered. `pt_ready`, `key_ready` and `busy` are combinational from registered state.
- `rand_in` is sampled only on accept cycles, KEY1 and empty-slot LOAD cycles. The bench must present a new value each of those cycles.

## Structure
- Package `midori64_feeder_pkg` holds:
  - constants SLOTS=3, DW=64, KW=128, RW=72
  - LFSR tap list
  - state enum {COLLECT, KEY1, LOAD, RUN, DRAIN}
- Sub-module `midori64_r_lfsr`: ports `clk`, `reset`, `en`, `q`[71:0]; parameter SEED.
- Top: FSM, 3-entry share buffer, slot/drain counters.

## Test plan
- **Key masking:** key 128'h687ded3b3c85b3f35b1009863e2a8cbf with random `rand_in` → after KEY1, the XOR of the key shares equals the key and `core_key2` ≠ key.
- **Single plaintext + flush:** pt 64'h42c20fd3b586879e, `enc_dec_in`=0, then flush → LOAD drives slot0 share XOR = pt and slots 1–2 XOR = 0. With the real core attached, the recombined output includes 64'h66bcdc6270d901cd and 64'h36f32dcf124ab057 (zero-plaintext slots).
- **Full batch:** three plaintexts back-to-back → `pt_ready` drops after the third. LOAD starts the next cycle with no flush. Each slot's share XOR matches its plaintext.
- **Back-pressure:** `pt_valid` held during RUN → `pt_ready`=0 until `batch_done`+1, then accepted.
- **Simultaneous `key_valid`/`pt_valid` with `count`=0** → key accepted, plaintext stalled one cycle (held across KEY1).
- **Reset asserted in RUN** → next cycle: `core_reset`=1, `core_r`=`R_SEED`, `pt_ready`=0 until a key is reloaded.
